izh_array: RTL and testbench

Time-multiplexed array of `N` Izhikevich neurons sharing one fixed-point update datapath, generalising the single-neuron core in width, channel count and firing mode. Each `tick` pulse starts a sweep that advances every neuron one Euler step, one neuron per clock, and publishes a spike vector on completion. It sits behind the Tiny Tapeout top level: currents come from dedicated inputs, and spikes and a monitored membrane value drive the outputs.

---
 rtl/izh_pkg.sv | 21 ++
 rtl/izh_step.sv | 57 +++++
 rtl/izh_array.sv | 162 ++++++++++++++++
 tb/tb_izh_array.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared types and constants for the time-multiplexed Izhikevich neuron array.
package izh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_RS = 1'b0;
  localparam logic MODE_CH = 1'b1;

  localparam int V_RESET = -65;
  localparam int U_RESET = -17;
  localparam int V_PEAK  = 30;
  localparam int C_RS    = -65;
  localparam int D_RS    = 8;
  localparam int C_CH    = -50;
  localparam int D_CH    = 2;

endpackage

// File: rtl/izh_step.sv
// Combinational single Euler step of one Izhikevich neuron with saturation.
module izh_step
  import izh_pkg::*;
#(
  parameter int W        = 16,
  parameter int IW       = 8,
  parameter int DT_SHIFT = 2,
  parameter int A_SHIFT  = 6
) (
  input  logic signed [W-1:0]  v_i,
  input  logic signed [W-1:0]  u_i,
  input  logic        [IW-1:0] cur_i,
  input  logic                 mode_i,
  output logic signed [W-1:0]  v_o,
  output logic signed [W-1:0]  u_o,
  output logic                 spike_o
);

  localparam int XW = 2*W + 2;
  localparam logic signed [XW-1:0] SMAX  = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN  = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [XW-1:0] K5    = XW'(5);
  localparam logic signed [XW-1:0] K140  = XW'(140);
  localparam logic signed [XW-1:0] KPEAK = XW'(V_PEAK);
  localparam logic signed [XW-1:0] KC_RS = XW'(C_RS);
  localparam logic signed [XW-1:0] KD_RS = XW'(D_RS);
  localparam logic signed [XW-1:0] KC_CH = XW'(C_CH);
  localparam logic signed [XW-1:0] KD_CH = XW'(D_CH);

  function automatic logic signed [XW-1:0] sat(input logic signed [XW-1:0] x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  logic signed [XW-1:0] vx, ux, ix, sq, dv, vn, un, vs, us, cx, dx, ud;

  always_comb begin
    vx = XW'(v_i);
    ux = XW'(u_i);
    ix = XW'(cur_i);
    sq = vx * vx;
    dv = (sq >>> 5) + K5 * vx + K140 - ux + ix;
    vn = vx + (dv >>> DT_SHIFT);
    // recovery uses the pre-update membrane value
    un = ux + (((vx >>> 2) - ux) >>> A_SHIFT);
    vs = sat(vn);
    us = sat(un);
    cx = (mode_i == MODE_CH) ? KC_CH : KC_RS;
    dx = (mode_i == MODE_CH) ? KD_CH : KD_RS;
    ud = sat(us + dx);
    spike_o = (vs >= KPEAK);
    v_o = spike_o ? cx[W-1:0] : vs[W-1:0];
    u_o = spike_o ? ud[W-1:0] : us[W-1:0];
  end

endmodule

// File: rtl/izh_array.sv
// N Izhikevich neurons sharing one step datapath, one neuron per clock per tick.
// Optional refractory counters are enabled with the IZH_REFRACTORY_EN macro.
module izh_array
  import izh_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 16,
  parameter int IW        = 8,
  parameter int DT_SHIFT  = 2,
  parameter int A_SHIFT   = 6,
  parameter int REF_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [N*IW-1:0]       cur_in,
  input  logic                  cfg_we,
  input  logic [$clog2(N)-1:0]  cfg_idx,
  input  logic                  cfg_mode,
  input  logic [$clog2(N)-1:0]  sel,
  output logic [N-1:0]          spike,
  output logic signed [W-1:0]   v_mon,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int IDXW = $clog2(N);

  state_e              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                start;
  logic                done_q;
  logic [N*IW-1:0]     cur_q;
  logic [N-1:0]        mode_q, shadow_q, spike_q;
  logic signed [W-1:0] v_q [N];
  logic signed [W-1:0] u_q [N];

  logic signed [W-1:0] step_v, step_u, new_v, new_u;
  logic                step_spk, new_spk;

  izh_step #(.W(W), .IW(IW), .DT_SHIFT(DT_SHIFT), .A_SHIFT(A_SHIFT)) u_step (
    .v_i     (v_q[idx_q]),
    .u_i     (u_q[idx_q]),
    .cur_i   (cur_q[idx_q*IW +: IW]),
    .mode_i  (mode_q[idx_q]),
    .v_o     (step_v),
    .u_o     (step_u),
    .spike_o (step_spk)
  );

`ifdef IZH_REFRACTORY_EN
  localparam int RW = $clog2(REF_TICKS + 1);
  logic [RW-1:0]       ref_q [N];
  logic                in_ref;
  logic signed [W-1:0] c_val;

  always_comb begin
    in_ref  = (ref_q[idx_q] != '0);
    c_val   = (mode_q[idx_q] == MODE_CH) ? W'(C_CH) : W'(C_RS);
    new_v   = in_ref ? c_val : step_v;
    new_u   = in_ref ? u_q[idx_q] : step_u;
    new_spk = in_ref ? 1'b0 : step_spk;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) ref_q[k] <= '0;
    end else if (state_q == ST_SWEEP) begin
      if (in_ref)        ref_q[idx_q] <= ref_q[idx_q] - 1'b1;
      else if (step_spk) ref_q[idx_q] <= RW'(REF_TICKS);
    end
  end
`else
  always_comb begin
    new_v   = step_v;
    new_u   = step_u;
    new_spk = step_spk;
  end

  // refractory length only matters when the counters are built
  if (REF_TICKS < 0) begin : g_ref_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) start = 1'b1;
      end
      ST_SWEEP: begin
        if (tick) begin
          if (pend_q) ovr_d  = 1'b1;
          else        pend_d = 1'b1;
        end
        if (idx_q == IDXW'(N-1)) state_d = ST_DONE;
        else                     idx_d   = idx_q + 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // a tick arriving as the pending one is consumed becomes the next pending
        if (pend_q) begin
          start  = 1'b1;
          pend_d = tick;
        end else if (tick) begin
          start = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_SWEEP;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
      cur_q    <= '0;
      mode_q   <= {N{MODE_RS}};
      shadow_q <= '0;
      spike_q  <= '0;
      for (int k = 0; k < N; k++) begin
        v_q[k] <= W'(V_RESET);
        u_q[k] <= W'(U_RESET);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      done_q  <= (state_q == ST_DONE);
      if (state_q == ST_DONE) spike_q <= shadow_q;
      if (start) cur_q <= cur_in;
      if (state_q == ST_SWEEP) begin
        v_q[idx_q]      <= new_v;
        u_q[idx_q]      <= new_u;
        shadow_q[idx_q] <= new_spk;
      end
      if (cfg_we) mode_q[cfg_idx] <= cfg_mode;
    end
  end

  assign spike   = spike_q;
  assign v_mon   = v_q[sel];
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_izh_array.sv
// Randomized self-checking bench for izh_array against an integer reference model.
module tb_izh_array;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 8;
  localparam int DT = 2;
  localparam int AS = 6;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                tick;
  logic [N*IW-1:0]     cur_in;
  logic                cfg_we;
  logic [1:0]          cfg_idx;
  logic                cfg_mode;
  logic [1:0]          sel;
  logic [N-1:0]        spike;
  logic signed [W-1:0] v_mon;
  logic                busy, done, overrun;

  int vectors = 0;
  int miscompares = 0;

  int mv [N];
  int mu [N];
  int mm [N];
  logic [N-1:0] mspk;

  izh_array #(.N(N), .W(W), .IW(IW), .DT_SHIFT(DT), .A_SHIFT(AS), .REF_TICKS(3)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .cur_in(cur_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .sel(sel),
    .spike(spike), .v_mon(v_mon), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int s);
    int d;
    d = 1 << s;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -65; mu[k] = -17; mm[k] = 0;
    end
    mspk = '0;
  endtask

  task automatic model_sweep(input logic [N*IW-1:0] cur);
    int i, v, u, dv, vn, un;
    for (int k = 0; k < N; k++) begin
      i  = int'(cur[k*IW +: IW]);
      v  = mv[k];
      u  = mu[k];
      dv = fdiv(v * v, 5) + 5 * v + 140 - u + i;
      vn = sat(v + fdiv(dv, DT));
      un = sat(u + fdiv(fdiv(v, 2) - u, AS));
      if (vn >= 30) begin
        mspk[k] = 1'b1;
        mv[k]   = (mm[k] == 1) ? -50 : -65;
        mu[k]   = sat(un + ((mm[k] == 1) ? 2 : 8));
      end else begin
        mspk[k] = 1'b0;
        mv[k]   = vn;
        mu[k]   = un;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      sel = 2'(k);
      #1;
      chk({tag, "_v"}, longint'(v_mon), longint'(mv[k]));
    end
    chk({tag, "_spike"}, longint'(spike), longint'(mspk));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic set_mode(input int idx, input int m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_mode = 1'(m);
    @(negedge clk);
    cfg_we = 1'b0;
    mm[idx] = m;
  endtask

  // drive one tick, wait for done, then compare every neuron with the model
  task automatic run_sweep(input string tag, input logic [N*IW-1:0] cur);
    int cnt;
    @(negedge clk);
    cur_in = cur; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cnt = 1;
    chk({tag, "_busy"}, longint'(busy), 1);
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, longint'(cnt), longint'(N + 2));
    model_sweep(cur);
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    logic [N*IW-1:0] c;
    reset_n = 1'b0; tick = 1'b0; cur_in = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_mode = 1'b0; sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all("reset");
    chk("reset_busy", longint'(busy), 0);
    chk("reset_overrun", longint'(overrun), 0);
    chk("reset_done", longint'(done), 0);

    run_sweep("zero", '0);
    sel = 2'd0; #1;
    chk("zero_v0_abs", longint'(v_mon), -74);

    do_reset();
    run_sweep("rs1", 32'h0000_00FF);
    run_sweep("rs2", 32'h0000_00FF);
    sel = 2'd0; #1;
    chk("rs2_spike0_abs", longint'(spike[0]), 1);
    chk("rs2_v0_abs", longint'(v_mon), -65);
    run_sweep("rs3", 32'h0000_00FF);

    do_reset();
    set_mode(0, 1);
    run_sweep("ch1", 32'h0000_00FF);
    run_sweep("ch2", 32'h0000_00FF);
    sel = 2'd0; #1;
    chk("ch2_spike0_abs", longint'(spike[0]), 1);
    chk("ch2_v0_abs", longint'(v_mon), -50);
    run_sweep("ch3", 32'h0000_00FF);

    do_reset();
    for (int it = 0; it < 10; it++) begin
      set_mode(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1)));
      run_sweep("rand", 32'($urandom));
    end

    // ticks at cycles 0, 2, 3: one pending, one overrun, two sweeps total
    do_reset();
    c = 32'($urandom);
    @(negedge clk);
    cur_in = c; tick = 1'b1;
    dcnt = 0;
    for (int cy = 1; cy <= 20; cy++) begin
      @(negedge clk);
      tick = (cy == 2 || cy == 3);
      if (done) dcnt++;
      if (cy == 3) chk("ovr_before", longint'(overrun), 0);
      if (cy == 5) chk("ovr_after", longint'(overrun), 1);
    end
    tick = 1'b0;
    chk("ovr_done_count", longint'(dcnt), 2);
    chk("ovr_sticky", longint'(overrun), 1);
    model_sweep(c);
    model_sweep(c);
    check_all("ovr");

    // reset two cycles into a sweep aborts it without a done
    do_reset();
    run_sweep("pre", 32'hFFFF_FFFF);
    @(negedge clk);
    cur_in = 32'hFFFF_FFFF; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", longint'(busy), 0);
    check_all("abort");
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    for (int cy = 0; cy < 10; cy++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", longint'(dcnt), 0);
    run_sweep("post", 32'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
